// File: rtl/elevator_pkg.sv
// Shared types and constants for the six-stop elevator request controller.
// Stops are indexed 0..5 = 1, 2, 2M, 3, 3M, 4.
package elevator_pkg;

  localparam int unsigned NUM_STOPS = 6;
  localparam int unsigned LED_W     = 10;

  typedef logic [NUM_STOPS-1:0] stops_t;

  // Bits 9 and 0 double as the motion interlock for the floor FSM.
  localparam logic [LED_W-1:0] DOOR_LED_MOVE = 10'b1000000001;
  localparam logic [LED_W-1:0] DOOR_LED_OPEN = 10'h3FF;
  localparam logic [LED_W-1:0] DOOR_LED_OFF  = 10'h000;

  typedef enum logic [1:0] {CLOSED, OPENING, OPEN, CLOSING} door_state_t;
  typedef enum logic [1:0] {IDLE, UP, DOWN} dir_state_t;

  // True only for exactly one bit set; zero and multi-hot are both invalid.
  function automatic logic is_one_hot(stops_t v);
    return (v != '0) && ((v & (v - stops_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/elevator_request_ctrl_door_sequencer.sv
// door_sequencer: door FSM (CLOSED -> OPENING -> OPEN -> CLOSING -> CLOSED) with a
// shared down-counter that is reloaded on every state entry, so each timed state
// lasts exactly its configured number of cycles.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   open_req_i         pending request at the present stop (CLOSED -> OPENING)
//   reopen_i           call button at the present stop (reloads OPEN, reopens CLOSING)
//   hold_i             door-hold button (freezes OPEN timer, reopens CLOSING)
//   floor_ok_i         present-stop vector is one-hot; when low, only timers run
//   state_o            current door state
//   entering_open_o    high in the cycle whose edge moves the door into OPEN
module door_sequencer
  import elevator_pkg::*;
#(
  parameter int unsigned TRANS_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        open_req_i,
  input  logic        reopen_i,
  input  logic        hold_i,
  input  logic        floor_ok_i,
  output door_state_t state_o,
  output logic        entering_open_o
);

  localparam int unsigned MaxCyc = (TRANS_CYCLES > HOLD_CYCLES) ? TRANS_CYCLES : HOLD_CYCLES;
  localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

  localparam logic [CntW-1:0] TransLoad = CntW'(TRANS_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLoad  = CntW'(HOLD_CYCLES - 1);

  door_state_t     state_d, state_q;
  logic [CntW-1:0] cnt_d, cnt_q, cnt_dec;
  logic            hold_act;

  // Hold may only push the door back open when the stop is valid.
  assign hold_act = hold_i & floor_ok_i;
  // Timers keep running while the stop is invalid but saturate at zero, so the
  // pending transition fires as soon as the stop becomes valid again.
  assign cnt_dec  = (cnt_q != '0) ? cnt_q - CntW'(1) : cnt_q;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    entering_open_o = 1'b0;
    unique case (state_q)
      CLOSED: begin
        if (open_req_i) begin
          state_d = OPENING;
          cnt_d   = TransLoad;
        end
      end
      OPENING: begin
        if (cnt_q == '0 && floor_ok_i) begin
          state_d         = OPEN;
          cnt_d           = HoldLoad;
          entering_open_o = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      OPEN: begin
        if (reopen_i) begin
          cnt_d = HoldLoad;
        end else if (hold_act) begin
          cnt_d = cnt_q;
        end else if (cnt_q == '0 && floor_ok_i) begin
          state_d = CLOSING;
          cnt_d   = TransLoad;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      CLOSING: begin
        if (reopen_i || hold_act) begin
          state_d = OPENING;
          cnt_d   = TransLoad;
        end else if (cnt_q == '0 && floor_ok_i) begin
          state_d = CLOSED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: begin
        state_d = CLOSED;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= CLOSED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/elevator_request_ctrl.sv
// elevator_request_ctrl: latches call-button requests until served, sequences the
// door at the served stop and holds the travel direction while requests remain ahead.
// Optional feature: define ELEVATOR_DOOR_HOLD_EN to add the holdBtn door-hold input.
// Ports:
//   Clock, Reset   clock, asynchronous active-high reset
//   callBtn        per-stop call buttons (bit 0 = 1st .. bit 5 = 4th)
//   currentFloor   one-hot present stop from the floor FSM
//   holdBtn        door-hold button (ELEVATOR_DOOR_HOLD_EN only)
//   pendingReq     latched outstanding requests
//   Up, Down       registered travel direction
//   doorLed        door indication; bits 9 and 0 are the motion interlock
module elevator_request_ctrl
  import elevator_pkg::*;
#(
  parameter int unsigned TRANS_CYCLES = 2,
  parameter int unsigned HOLD_CYCLES  = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_STOPS-1:0] callBtn,
  input  logic [NUM_STOPS-1:0] currentFloor,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic                 holdBtn,
`endif
  output logic [NUM_STOPS-1:0] pendingReq,
  output logic                 Up,
  output logic                 Down,
  output logic [LED_W-1:0]     doorLed
);

  stops_t      pending_d, pending_q;
  dir_state_t  dir_d, dir_q;
  door_state_t door_state;
  logic        entering_open;
  logic        floor_ok;
  logic        floor_match;
  logic        floor_press;
  logic        hold;
  stops_t      clr;
  stops_t      below_mask;
  logic        above;
  logic        below;

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign hold = holdBtn;
`else
  assign hold = 1'b0;
`endif

  assign floor_ok    = is_one_hot(currentFloor);
  assign floor_match = floor_ok & (|(pending_q & currentFloor));
  assign floor_press = floor_ok & (|(callBtn & currentFloor));

  // For a one-hot stop, (stop - 1) sets exactly the bits below it.
  assign below_mask = currentFloor - stops_t'(1);
  assign below      = |(pending_q & below_mask);
  assign above      = |(pending_q & ~(below_mask | currentFloor));

  door_sequencer #(
    .TRANS_CYCLES (TRANS_CYCLES),
    .HOLD_CYCLES  (HOLD_CYCLES)
  ) u_door (
    .clk_i           (Clock),
    .rst_i           (Reset),
    .open_req_i      (floor_match),
    .reopen_i        (floor_press),
    .hold_i          (hold),
    .floor_ok_i      (floor_ok),
    .state_o         (door_state),
    .entering_open_o (entering_open)
  );

  // Clear has priority over a same-cycle press on the same bit.
  always_comb begin
    clr = '0;
    if (floor_ok && (entering_open || door_state == OPEN)) begin
      clr = currentFloor;
    end
    pending_d = (pending_q | callBtn) & ~clr;
  end

  // Direction only moves while the door is shut and the stop is valid.
  always_comb begin
    dir_d = dir_q;
    if (door_state == CLOSED && floor_ok) begin
      unique case (dir_q)
        IDLE: begin
          if (above)      dir_d = UP;
          else if (below) dir_d = DOWN;
        end
        UP: begin
          if (above)      dir_d = UP;
          else if (below) dir_d = DOWN;
          else            dir_d = IDLE;
        end
        DOWN: begin
          if (below)      dir_d = DOWN;
          else if (above) dir_d = UP;
          else            dir_d = IDLE;
        end
        default: dir_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pending_q <= '0;
      dir_q     <= IDLE;
    end else begin
      pending_q <= pending_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    doorLed = DOOR_LED_OFF;
    unique case (door_state)
      CLOSED:           doorLed = DOOR_LED_OFF;
      OPENING, CLOSING: doorLed = DOOR_LED_MOVE;
      OPEN:             doorLed = DOOR_LED_OPEN;
      default:          doorLed = DOOR_LED_OFF;
    endcase
  end

  assign pendingReq = pending_q;
  assign Up         = (dir_q == UP);
  assign Down       = (dir_q == DOWN);

endmodule

// File: tb/tb_elevator_request_ctrl.sv
// Scoreboard bench for elevator_request_ctrl. The driver applies inputs on the
// falling edge, steps a behavioural model and queues the outputs expected after
// the next rising edge; the monitor pops and compares shortly after each rising edge.
module tb_elevator_request_ctrl;

  localparam int TRANS = 2;
  localparam int HOLD  = 4;

  localparam int PH_CLOSED  = 0;
  localparam int PH_OPENING = 1;
  localparam int PH_OPEN    = 2;
  localparam int PH_CLOSING = 3;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [5:0] callBtn;
  logic [5:0] currentFloor;
  logic [5:0] pendingReq;
  logic       Up;
  logic       Down;
  logic [9:0] doorLed;
`ifdef ELEVATOR_DOOR_HOLD_EN
  logic       holdBtn = 1'b0;
`endif

  always #5 Clock = ~Clock;

  elevator_request_ctrl #(
    .TRANS_CYCLES (TRANS),
    .HOLD_CYCLES  (HOLD)
  ) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .callBtn      (callBtn),
    .currentFloor (currentFloor),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .holdBtn      (holdBtn),
`endif
    .pendingReq   (pendingReq),
    .Up           (Up),
    .Down         (Down),
    .doorLed      (doorLed)
  );

  typedef struct packed {
    logic [5:0] pend;
    logic [1:0] dir;   // {Up, Down}
    logic [9:0] led;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle    = 0;

  // Model state: door phase with cycles left in it, direction as +1/0/-1.
  int         m_phase;
  int         m_rem;
  int         m_dir;
  logic [5:0] m_pend;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cycle, act, exp);
    end
  endtask

  function automatic logic [9:0] led_of(input int ph);
    if (ph == PH_CLOSED) return 10'h000;
    if (ph == PH_OPEN)   return 10'h3FF;
    return 10'h201;
  endfunction

  task automatic model_reset();
    m_phase = PH_CLOSED;
    m_rem   = 0;
    m_dir   = 0;
    m_pend  = '0;
  endtask

  // One clock of the elevator rules, evaluated on pre-edge state and inputs.
  task automatic model_step(input logic [5:0] cb, input logic [5:0] cf);
    int         ones     = $countones(cf);
    bit         ok       = (ones == 1);
    int         idx      = 0;
    bit         above    = 0;
    bit         below    = 0;
    bit         match;
    bit         press;
    bit         entering = 0;
    int         ph_now   = m_phase;
    logic [5:0] clr      = '0;
    exp_t       e;
    for (int i = 0; i < 6; i++) if (cf[i]) idx = i;
    for (int i = 0; i < 6; i++) begin
      if (m_pend[i] && i > idx) above = 1;
      if (m_pend[i] && i < idx) below = 1;
    end
    match = ok && ((m_pend & cf) != 0);
    press = ok && ((cb & cf) != 0);
    case (m_phase)
      PH_CLOSED: if (match) begin m_phase = PH_OPENING; m_rem = TRANS; end
      PH_OPENING: begin
        if (m_rem == 1 && ok) begin m_phase = PH_OPEN; m_rem = HOLD; entering = 1; end
        else if (m_rem > 1) m_rem--;
      end
      PH_OPEN: begin
        if (press) m_rem = HOLD;
        else if (m_rem == 1 && ok) begin m_phase = PH_CLOSING; m_rem = TRANS; end
        else if (m_rem > 1) m_rem--;
      end
      default: begin
        if (press) begin m_phase = PH_OPENING; m_rem = TRANS; end
        else if (m_rem == 1 && ok) begin m_phase = PH_CLOSED; m_rem = 0; end
        else if (m_rem > 1) m_rem--;
      end
    endcase
    if (ok && (entering || ph_now == PH_OPEN)) clr = cf;
    if (ph_now == PH_CLOSED && ok) begin
      if (m_dir == 1)       m_dir = above ? 1 : (below ? -1 : 0);
      else if (m_dir == -1) m_dir = below ? -1 : (above ? 1 : 0);
      else                  m_dir = above ? 1 : (below ? -1 : 0);
    end
    m_pend = (m_pend | cb) & ~clr;
    e.pend = m_pend;
    e.dir  = {m_dir == 1, m_dir == -1};
    e.led  = led_of(m_phase);
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic drive(input logic [5:0] cb, input logic [5:0] cf);
    callBtn      = cb;
    currentFloor = cf;
    model_step(cb, cf);
    @(negedge Clock);
  endtask

  task automatic idle(input int n, input logic [5:0] cf);
    for (int i = 0; i < n; i++) drive(6'b0, cf);
  endtask

  // Asynchronous reset between edges; outputs must clear before the next edge.
  task automatic mid_reset();
    #2 Reset = 1'b1;
    #1;
    check("async_pending", 32'(pendingReq), 32'h0);
    check("async_dir", 32'({Up, Down}), 32'h0);
    check("async_led", 32'(doorLed), 32'h0);
    model_reset();
    exp_q.delete();
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge Clock);
      #1;
      cycle++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pendingReq", 32'(pendingReq), 32'(e.pend));
        check("up_down", 32'({Up, Down}), 32'(e.dir));
        check("doorLed", 32'(doorLed), 32'(e.led));
        if (Up && Down) check("up_down_exclusive", 32'({Up, Down}), 32'h0);
      end
    end
  end

  initial begin : driver
    int         fl;
    logic [5:0] cf;
    logic [5:0] cb;
    Reset        = 1'b1;
    callBtn      = '0;
    currentFloor = 6'b000001;
    model_reset();
    @(negedge Clock);
    check("reset_pending", 32'(pendingReq), 32'h0);
    check("reset_led", 32'(doorLed), 32'h0);
    @(negedge Clock);
    Reset = 1'b0;

    // Quiet after reset.
    idle(10, 6'b000001);

    // Request 3 from 1, then arrive and serve it.
    drive(6'b001000, 6'b000001);
    idle(3, 6'b000001);
    idle(14, 6'b001000);

    // At 3M travelling up with requests at 4 and 1.
    drive(6'b100000, 6'b001000);
    idle(2, 6'b001000);
    idle(2, 6'b010000);
    drive(6'b000001, 6'b010000);
    idle(3, 6'b010000);
    idle(14, 6'b100000);

    // Reload during OPEN (hold-cycle 3) and reopen during CLOSING.
    drive(6'b100000, 6'b100000);
    idle(5, 6'b100000);
    drive(6'b100000, 6'b100000);
    idle(4, 6'b100000);
    drive(6'b100000, 6'b100000);
    idle(14, 6'b100000);

    // Press lands on the edge the door enters OPEN: must stay clear.
    drive(6'b100000, 6'b100000);
    idle(2, 6'b100000);
    drive(6'b100000, 6'b100000);
    idle(14, 6'b100000);

    // Reset during OPEN with requests 110000 outstanding.
    drive(6'b000001, 6'b000001);
    drive(6'b000000, 6'b000001);
    drive(6'b110000, 6'b000001);
    idle(3, 6'b000001);
    mid_reset();
    idle(3, 6'b000001);

    // Randomized traffic, including occasional invalid stop vectors.
    fl = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(11) == 0) fl = $urandom_range(5);
      cf = 6'b000001 << fl;
      if ($urandom_range(29) == 0) cf = (($urandom_range(1) == 0) ? 6'b000000 : 6'b100001);
      cb = '0;
      if ($urandom_range(5) == 0) cb = 6'b000001 << $urandom_range(5);
      if ($urandom_range(49) == 0) cb = 6'($urandom);
      drive(cb, cf);
      if (n == 1500) mid_reset();
    end
    idle(2, cf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/elevator_request_ctrl.md
# elevator_request_ctrl

Request latch, door sequencer and direction controller for the six-stop elevator (1, 2, 2M, 3, 3M, 4). It sits directly upstream of the floor-position FSM:
- Its outputs feed that FSM's request vector, Up/Down and door-interlock LEDs.
- It consumes the FSM's one-hot `currentFloor` back.

Button presses are latched until served. The door is cycled open and closed at the served floor, and travel direction is held until no requests remain ahead.

## Interface
- `TRANS_CYCLES`, default 2: cycles spent in OPENING and in CLOSING (≥1).
- `HOLD_CYCLES`, default 4: cycles spent in OPEN (≥1).

Ports:
- `Clock`  in  1  single clock; all state changes on its rising edge.
- `Reset`  in  1  asynchronous, active-high; clears all state immediately.
- `callBtn`  in  6  floor call buttons, bit i = stop i (0 = 1st … 5 = 4th). Level or pulse; each high cycle is a request.
- `currentFloor`  in  6  one-hot present stop from the floor FSM.
- `pendingReq`  out  6  latched outstanding requests (drives the floor FSM request input).
- `Up`  out  1  travelling up.
- `Down`  out  1  travelling down.
- `doorLed`  out  10  door indication. Bits 9 and 0 also serve as the motion interlock.
- `holdBtn`  in  1  door-hold button; present only with `DOOR_HOLD_EN`.

## Operation
Reset values: `pendingReq`=0, `Up`=0, `Down`=0, `doorLed`=0, door=CLOSED, direction=IDLE, door counter=0.

Request latch:
- `pendingReq <= (pendingReq | callBtn) & ~clr`.
- `clr` = `currentFloor` for the one cycle in which the door enters OPEN, and every cycle the door is in OPEN.
- If set and clear fall on the same bit in the same cycle, clear wins.

Door FSM (states CLOSED, OPENING, OPEN, CLOSING):
- CLOSED → OPENING when `|(pendingReq & currentFloor)`.
- OPENING → OPEN after `TRANS_CYCLES`.
- OPEN → CLOSING after `HOLD_CYCLES`. A `callBtn` press at the current floor during OPEN reloads the hold count.
- CLOSING → CLOSED after `TRANS_CYCLES`. A `callBtn` press at the current floor during CLOSING goes to OPENING with the counter reloaded.
- The counter reloads on every state entry.

`doorLed`:
- CLOSED: 0.
- OPENING and CLOSING: bits 9 and 0 only (10'b1000000001).
- OPEN: all ones.
- The floor FSM moves only when bits 9 and 0 are both low.

Direction FSM (IDLE, UP, DOWN), updated only while the door is CLOSED and otherwise frozen:
- `above` = any pending bit at an index greater than the current floor index. `below` = any pending bit at a lower index.
- IDLE: `above` → UP; else `below` → DOWN.
- UP: stay while `above`; else `below` → DOWN; else IDLE.
- DOWN: mirror of UP.
- `Up` = (state==UP) and `Down` = (state==DOWN), both registered. They are never both 1.

If `currentFloor` is not one-hot (zero or multi-hot):
- no floor match occurs and no `clr` is issued;
- direction holds;
- the door FSM stays in its present state except for its timers.

## Timing
- `callBtn` high in cycle n → `pendingReq` bit set after edge n+1.
- Request at the current floor → door enters OPENING one edge after `pendingReq` shows it.
- Full door cycle = 2·`TRANS_CYCLES` + `HOLD_CYCLES` cycles.
- The request bit is low the cycle after entering OPEN.
- Direction output updates one edge after `pendingReq`/`currentFloor` change (door CLOSED).
- `Reset` asserted mid-cycle: every output goes to its reset value asynchronously. Requests are lost.

## Configuration
`ELEVATOR_DOOR_HOLD_EN`:
- Defined:
  - `holdBtn` port exists.
  - While `holdBtn`=1 in OPEN, the hold counter does not decrement.
  - While `holdBtn`=1 in CLOSING, the door returns to OPENING.
- Undefined: no port, no hold logic. Behaviour is otherwise identical.

## Structure
- Package `elevator_pkg`:
  - `NUM_STOPS`=6;
  - `door_state_t` {CLOSED, OPENING, OPEN, CLOSING};
  - `dir_state_t` {IDLE, UP, DOWN};
  - `DOOR_LED_MOVE`=10'b1000000001 and `DOOR_LED_OPEN`=10'h3FF.
- Sub-module `door_sequencer`: door FSM plus down-counter. Inputs are the open request, reopen and hold. Outputs are the state and an `enteringOpen` pulse.
- Latch and direction logic live in the top.

## Test plan
All scenarios use defaults (TRANS=2, HOLD=4).
- Reset released, `currentFloor`=000001, `callBtn`=000000 for 10 cycles → `pendingReq`=0, `Up`=`Down`=0, `doorLed`=0.
- `currentFloor`=000001, pulse `callBtn`=001000 → `pendingReq`=001000 next cycle, `Up`=1 the cycle after; `currentFloor`→001000 → door cycles 2/4/2 cycles, `doorLed`=3FF for 4 cycles, `pendingReq`=0, then `Up`=0.
- At stop 3M, `Up`=1, pending {100000, 000001} → `Up` held until 4 is served, then `Down`=1.
- During OPEN, press current floor on hold-cycle 3 → OPEN lasts 4 more cycles. Press during CLOSING → back to OPENING, `doorLed`=201.
- `callBtn` = current floor on the same edge the door enters OPEN → bit stays clear, no second door cycle.
- `Reset` asserted during OPEN with `pendingReq`=110000 → all outputs 0 asynchronously, before the next edge.
